// File: rtl/addergen_pipe.sv
// Pipelined unsigned add/subtract: SIZE-bit carry chain split into STAGES slices, valid/ready flow control.
// Define SAT_EN to clamp the result on overflow (add) or borrow (sub); co is reported either way.
module addergen_pipe #(
    parameter int SIZE   = 16,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            ci,
    input  logic            sub,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] sum,
    output logic            co
);

    localparam int W = SIZE / STAGES;

    if ((STAGES < 1) || (STAGES > SIZE) || ((SIZE % STAGES) != 0)) begin : g_bad_cfg
        $error("addergen_pipe: SIZE must be a multiple of STAGES and 1 <= STAGES <= SIZE");
    end

    logic [STAGES:0]   v;
    logic [STAGES:0]   en;
    logic [SIZE-1:0]   a_q [0:STAGES-1];
    logic [SIZE-1:0]   b_q [0:STAGES-1];
    logic [SIZE-1:0]   s_q [0:STAGES];
    logic [STAGES:0]   c_q;
    logic [SIZE-1:0]   s_d [1:STAGES];
    logic [STAGES:1]   c_d;
    logic [W:0]        slice;
`ifdef SAT_EN
    logic [STAGES-1:0] sub_q;
`endif

    // Only the top slice of the last skew register is consumed.
    logic unused_skew;
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1]};

    // A stage may load when it is empty or its successor is moving.
    always_comb begin
        logic chain;
        en    = '0;
        chain = ~v[STAGES] | out_ready;
        en[STAGES] = chain;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain = ~v[k] | chain;
            en[k] = chain;
        end
    end

    assign in_ready  = en[0];
    assign out_valid = v[STAGES];
    assign sum       = s_q[STAGES];
    assign co        = c_q[STAGES];

    always_comb begin
        slice = '0;
        c_d   = '0;
        for (int k = 1; k <= STAGES; k++) begin
            s_d[k] = s_q[k-1];
            slice  = {1'b0, a_q[k-1][(k-1)*W +: W]}
                   + {1'b0, b_q[k-1][(k-1)*W +: W]}
                   + {{W{1'b0}}, c_q[k-1]};
            s_d[k][(k-1)*W +: W] = slice[W-1:0];
            c_d[k] = slice[W];
        end
`ifdef SAT_EN
        if (!sub_q[STAGES-1] && c_d[STAGES]) begin
            s_d[STAGES] = '1;
        end else if (sub_q[STAGES-1] && !c_d[STAGES]) begin
            s_d[STAGES] = '0;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v   <= '0;
            c_q <= '0;
`ifdef SAT_EN
            sub_q <= '0;
`endif
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            for (int k = 0; k <= STAGES; k++) begin
                s_q[k] <= '0;
            end
        end else begin
            // Subtraction is a + ~b + ~ci, so the inversion happens once on entry.
            if (en[0]) begin
                v[0]   <= in_valid;
                a_q[0] <= a;
                b_q[0] <= sub ? ~b : b;
                c_q[0] <= sub ? ~ci : ci;
`ifdef SAT_EN
                sub_q[0] <= sub;
`endif
            end
            for (int k = 1; k < STAGES; k++) begin
                if (en[k]) begin
                    a_q[k] <= a_q[k-1];
                    b_q[k] <= b_q[k-1];
`ifdef SAT_EN
                    sub_q[k] <= sub_q[k-1];
`endif
                end
            end
            for (int k = 1; k <= STAGES; k++) begin
                if (en[k]) begin
                    v[k]   <= v[k-1];
                    s_q[k] <= s_d[k];
                    c_q[k] <= c_d[k];
                end
            end
        end
    end

endmodule
